// File: rtl/rx_frame_buffer.sv
// Receive-frame buffer: a ring of frame slots written by the MAC and read by the host.
// Frames become visible only on commit; frames arriving with no free slot are counted as drops.
module rx_frame_buffer #(
   parameter  int slot_p        = 4,
   parameter  int data_width_p  = 64,
   parameter  int els_p         = 2048,
   parameter  int size_width_p  = 16,
   parameter  int drop_width_p  = 16,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int lsb_lp        = $clog2(data_width_p/8),
   localparam int occ_w_lp      = $clog2(slot_p+1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     wr_start_i,
   input  logic                     wr_v_i,
   input  logic [addr_width_lp-1:0] wr_addr_i,
   input  logic [data_width_p-1:0]  wr_data_i,
   input  logic                     wr_commit_i,
   input  logic [size_width_p-1:0]  wr_size_i,
   input  logic                     wr_abort_i,
   output logic                     wr_busy_o,
   output logic                     wr_drop_o,
   output logic [drop_width_p-1:0]  drop_count_o,
   output logic                     rd_slot_v_o,
   output logic [size_width_p-1:0]  rd_size_o,
   input  logic                     rd_slot_yumi_i,
   input  logic                     rd_v_i,
   input  logic [addr_width_lp-1:0] rd_addr_i,
   input  logic [1:0]               rd_op_size_i,
   output logic                     rd_data_v_o,
   output logic [data_width_p-1:0]  rd_data_o,
   output logic [occ_w_lp-1:0]      occupancy_o
);

   localparam int ptr_w_lp   = $clog2(slot_p);
   localparam int bytes_lp   = data_width_p/8;
   localparam int words_lp   = els_p/bytes_lp;
   localparam int waddr_w_lp = addr_width_lp-lsb_lp;

   typedef enum logic [1:0] {IDLE, OPEN, DROP} state_e;

   state_e                   state_q, state_d;
   logic [ptr_w_lp-1:0]      tail_q, tail_d;
   logic [ptr_w_lp-1:0]      head_q, head_d;
   logic [occ_w_lp-1:0]      occ_q, occ_d;
   logic [drop_width_p-1:0]  drop_q, drop_d;
   logic                     rd_v_q, rd_v_d;
   logic [data_width_p-1:0]  rd_word_q, rd_word_d;
   logic [lsb_lp-1:0]        off_q, off_d;
   logic [1:0]               op_q, op_d;

   logic [data_width_p-1:0]  mem_q  [slot_p][words_lp];
   logic [size_width_p-1:0]  size_q [slot_p];

   logic                     wr_en, commit, yumi, rd_acc, full;
   logic [lsb_lp-1:0]        amask;
   logic [waddr_w_lp-1:0]    wr_word, rd_word_addr;
   logic [data_width_p-1:0]  shifted;
   logic                     unused_wr_lsb;

   assign full          = (occ_q == occ_w_lp'(slot_p));
   assign yumi          = rd_slot_yumi_i & rd_slot_v_o;
   assign rd_acc        = rd_v_i & rd_slot_v_o;
   assign wr_word       = wr_addr_i[addr_width_lp-1:lsb_lp];
   assign rd_word_addr  = rd_addr_i[addr_width_lp-1:lsb_lp];
   assign unused_wr_lsb = ^wr_addr_i[lsb_lp-1:0];

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_start_i) begin
               if (full) begin
                  state_d = DROP;
                  if (drop_q != '1) drop_d = drop_q + 1'b1;
               end else begin
                  state_d = OPEN;
               end
            end
         end
         OPEN: begin
            wr_en = wr_v_i;
            // abort takes priority over a simultaneous commit
            if (wr_abort_i) begin
               state_d = IDLE;
            end else if (wr_commit_i) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (wr_commit_i || wr_abort_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      tail_d = tail_q + ptr_w_lp'(commit);
      head_d = head_q + ptr_w_lp'(yumi);
      occ_d  = occ_q + occ_w_lp'(commit) - occ_w_lp'(yumi);
   end

   // oversize ops collapse to a full-word read
   always_comb begin
      op_d = rd_op_size_i;
      if (int'(rd_op_size_i) > lsb_lp) op_d = 2'(lsb_lp);
      amask     = {lsb_lp{1'b1}} << op_d;
      off_d     = rd_addr_i[lsb_lp-1:0] & amask;
      rd_v_d    = rd_acc;
      rd_word_d = mem_q[head_q][rd_word_addr];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         tail_q    <= '0;
         head_q    <= '0;
         occ_q     <= '0;
         drop_q    <= '0;
         rd_v_q    <= 1'b0;
         rd_word_q <= '0;
         off_q     <= '0;
         op_q      <= '0;
      end else begin
         state_q <= state_d;
         tail_q  <= tail_d;
         head_q  <= head_d;
         occ_q   <= occ_d;
         drop_q  <= drop_d;
         rd_v_q  <= rd_v_d;
         if (rd_acc) begin
            rd_word_q <= rd_word_d;
            off_q     <= off_d;
            op_q      <= op_d;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[tail_q][wr_word] <= wr_data_i;
      if (commit) size_q[tail_q] <= wr_size_i;
   end

   always_comb begin
      shifted = rd_word_q >> {off_q, 3'b000};
      for (int i = 0; i < bytes_lp; i++) begin
         rd_data_o[8*i +: 8] = (i < (1 << op_q)) ? shifted[8*i +: 8] : 8'h00;
      end
   end

   assign wr_busy_o    = (state_q == OPEN);
   assign wr_drop_o    = (state_q == DROP);
   assign drop_count_o = drop_q;
   assign rd_slot_v_o  = (occ_q != '0);
   assign rd_size_o    = size_q[head_q];
   assign rd_data_v_o  = rd_v_q;
   assign occupancy_o  = occ_q;

   a_start_open: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(wr_start_i && state_q != IDLE))
      else $error("wr_start while a frame is open");

   a_op_size: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(rd_acc && int'(rd_op_size_i) > lsb_lp))
      else $error("read op size wider than a word");

   a_align: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(rd_acc && (rd_addr_i[lsb_lp-1:0] & ~amask) != '0))
      else $warning("misaligned read address aligned down");

endmodule
